// File: rtl/sha3_pkg.sv
// Shared SHA3 package: digest transmitter state encoding, digest widths and
// the byte-reversal helper used when SHA3_DIGEST_BYTESWAP_EN is defined.
package sha3_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } digest_tx_state_e;

   localparam int SHA3_224_W = 224;
   localparam int SHA3_256_W = 256;
   localparam int SHA3_384_W = 384;
   localparam int SHA3_512_W = 512;

   // Reverses the lowest nbytes bytes of a word of up to 64 bits.
   function automatic logic [63:0] byteswap(input logic [63:0] w, input int unsigned nbytes);
      logic [63:0] r;
      r = 64'd0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < nbytes) begin
            r[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sha3_digest_tx.sv
// Captures the SHA3 digest when the core reports ready and streams it out as
// WORD_W-bit words over valid/ready. Optional macro: SHA3_DIGEST_BYTESWAP_EN.
module sha3_digest_tx
   import sha3_pkg::*;
#(
   parameter int DIGEST_W = 256,
   parameter int WORD_W   = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hash_ready,
   input  logic [DIGEST_W-1:0] digest_in,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   localparam int NUM_WORDS = DIGEST_W / WORD_W;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

   digest_tx_state_e    r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DIGEST_W-1:0] r_hold;
   logic                r_valid;
   logic [WORD_W-1:0]   r_data;
   logic                r_last;
   logic                r_busy;
   logic                r_done;

   logic [WORD_W-1:0]   w_words [NUM_WORDS];
   logic [CNT_W-1:0]    w_cnt_inc;
   logic [WORD_W-1:0]   w_first_raw;
   logic [WORD_W-1:0]   w_next_raw;

   // Output word formatting; byte reversal turns Keccak LE lanes into BE bytes.
   function automatic logic [WORD_W-1:0] fmt_word(input logic [WORD_W-1:0] w);
`ifdef SHA3_DIGEST_BYTESWAP_EN
      logic [63:0] pad;
      logic [63:0] swapped;
      pad            = 64'd0;
      pad[WORD_W-1:0] = w;
      swapped        = byteswap(pad, WORD_W / 8);
      return swapped[WORD_W-1:0];
`else
      return w;
`endif
   endfunction

   // Slice the holding register into words, word 0 in the LSBs.
   always_comb begin
      for (int i = 0; i < NUM_WORDS; i++) begin
         w_words[i] = r_hold[i*WORD_W +: WORD_W];
      end
   end

   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_first_raw = digest_in[WORD_W-1:0];
   assign w_next_raw  = w_words[w_cnt_inc];

   // Transfer FSM; outputs are registered and preloaded one word ahead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_hold  <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (hash_ready) begin
                  r_hold  <= digest_in;
                  r_cnt   <= '0;
                  r_state <= SEND;
                  r_valid <= 1'b1;
                  r_data  <= fmt_word(w_first_raw);
                  r_last  <= (LAST_CNT == '0);
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (r_cnt == LAST_CNT) begin
                     r_state <= DRAIN;
                     r_valid <= 1'b0;
                     r_data  <= '0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt  <= w_cnt_inc;
                     r_data <= fmt_word(w_next_raw);
                     r_last <= (w_cnt_inc == LAST_CNT);
                  end
               end else begin
                  r_state <= SEND;
               end
            end
            // The core parks in its ready state; it must drop before a new capture.
            DRAIN: begin
               if (!hash_ready) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= DRAIN;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_valid <= 1'b0;
               r_data  <= '0;
               r_last  <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_last  = r_last;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
